// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the shared-ALU arbiter: opcodes, widths, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents:
//   ALU_OP_W, XLEN       opcode and datapath widths
//   ALU_ADD..ALU_SLTU    legal opcodes; 10..15 are illegal
//   arb_state_t          arbiter FSM encoding (ARB_IDLE/ARB_EXEC/ARB_RESP)
//   alu_req_t            latched request (opcode + operands)
package alu_share_arbiter_pkg;

    localparam int ALU_OP_W = 4;
    localparam int XLEN     = 32;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ALU_OP_W-1:0] op;
        logic [XLEN-1:0]     a;
        logic [XLEN-1:0]     b;
    } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_alu_core.sv
// Purely combinational 32-bit integer ALU (add/sub/logic/shifts/compares).
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   op       in   opcode (see package)
//   a, b     in   operands; shift amount is b[4:0]
//   y        out  result, 0 for illegal opcodes
//   illegal  out  opcode outside ALU_ADD..ALU_SLTU
module alu_core
    import alu_share_arbiter_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic [XLEN-1:0]     y,
    output logic                illegal
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ valid/ready requesters; one ID-tagged response channel.
// Latency: grant in cycle T -> resp_valid in T+2; at most one op every 3 cycles.
// Backpressure: resp_ready low holds the response in RESP and blocks all new grants.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake; req_ready is a one-hot grant
//   req_op/req_a/req_b       packed per-requester opcode and operands
//   resp_valid/resp_ready    shared response handshake
//   resp_data/resp_id/resp_err  result, granted requester index, illegal-opcode flag
// Configuration: define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// the default build uses round-robin starting after the last served requester.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [ALU_OP_W*NUM_REQ-1:0]  req_op,
    input  logic [XLEN*NUM_REQ-1:0]      req_a,
    input  logic [XLEN*NUM_REQ-1:0]      req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [XLEN-1:0]              resp_data,
    output logic [ID_W-1:0]              resp_id,
    output logic                         resp_err
);

    arb_state_t          state;
    arb_state_t          state_nxt;

    logic                grant_vld;
    logic [ID_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]  grant_oh;
    alu_req_t            sel_req;

    alu_req_t            lat_req;
    logic [ID_W-1:0]     lat_id;

    logic [XLEN-1:0]     alu_y;
    logic                alu_illegal;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Index of the requester served last; the search starts just after it.
    logic [ID_W-1:0]     rr_ptr;
`endif

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        // Scan from the top down so the lowest set index is the last writer.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(k);
            end
        end
`else
        // First valid requester at rr_ptr+1, rr_ptr+2, ... with wrap.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
`endif
        // Grants only exist in IDLE and never while reset is asserted.
        if ((state != ARB_IDLE) || rst) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh = NUM_REQ'(1) << grant_idx;
        end
    end

    assign req_ready = grant_oh;

    // Operand mux for the granted requester.
    always_comb begin
        sel_req.op = req_op[int'(grant_idx)*ALU_OP_W +: ALU_OP_W];
        sel_req.a  = req_a[int'(grant_idx)*XLEN +: XLEN];
        sel_req.b  = req_b[int'(grant_idx)*XLEN +: XLEN];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (grant_vld)  state_nxt = ARB_EXEC;
            ARB_EXEC:                 state_nxt = ARB_RESP;
            ARB_RESP: if (resp_ready) state_nxt = ARB_IDLE;
            default:                  state_nxt = ARB_IDLE;
        endcase
    end

    assign resp_valid = (state == ARB_RESP);

    // ------------------------------------------------------------------
    // ALU on the latched operands
    // ------------------------------------------------------------------
    alu_core u_alu_core (
        .op      (lat_req.op),
        .a       (lat_req.a),
        .b       (lat_req.b),
        .y       (alu_y),
        .illegal (alu_illegal)
    );

    // ------------------------------------------------------------------
    // Operand latches, response registers, rotation pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_req   <= '0;
            lat_id    <= '0;
            resp_data <= '0;
            resp_id   <= '0;
            resp_err  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            // Points at the last index so requester 0 wins first.
            rr_ptr    <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            if (grant_vld) begin
                lat_req <= sel_req;
                lat_id  <= grant_idx;
            end
            // Response registers only load in EXEC, so they stay stable in RESP.
            if (state == ARB_EXEC) begin
                resp_data <= alu_y;
                resp_id   <= lat_id;
                resp_err  <= alu_illegal;
            end
`ifndef ALU_ARB_FIXED_PRIO_EN
            if ((state == ARB_RESP) && resp_ready) begin
                rr_ptr <= lat_id;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [4*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [ID_W-1:0]       resp_id;
    logic                  resp_err;

    int total;
    int bad;

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: loads one requester's opcode and operands.
    task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[4*r +: 4]   = op;
        req_a[32*r +: 32]  = a;
        req_b[32*r +: 32]  = b;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
        end
        total++;
        if ({resp_valid, resp_data, resp_id, resp_err} !== 36'h0) begin
            bad++; $display("FAIL reset_outputs: got valid=%b data=%h id=%0d err=%b want all zero",
                            resp_valid, resp_data, resp_id, resp_err);
        end
        rst       = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL idle_no_req: got ready=%b valid=%b want 0000/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_basic_or;
        set_req(0, 4'd3, 32'hF0F0_0000, 32'h0000_0F0F);
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL or_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;  // dropped after grant; op must still finish
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL or_exec: got valid=%b ready=%b want 0/0000", resp_valid, req_ready);
        end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hF0F0_0F0F || resp_id !== 2'd0 || resp_err !== 1'b0) begin
            bad++; $display("FAIL or_resp: got valid=%b data=%h id=%0d err=%b want 1/f0f00f0f/0/0",
                            resp_valid, resp_data, resp_id, resp_err);
        end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL or_back_idle: got valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_rotation;
        logic [3:0]  exp_oh;
        logic [31:0] exp_d;
        int          e;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 4'd0, 32'h100 * (i + 1), i);
        end
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            e = 0;
`else
            e = n % NUM_REQ;
`endif
            exp_oh = 4'b0001 << e;
            exp_d  = 32'h100 * (e + 1) + e;
            #1;
            total++;
            if (req_ready !== exp_oh) begin
                bad++; $display("FAIL rot_grant[%0d]: got %b want %b", n, req_ready, exp_oh);
            end
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0000) begin
                bad++; $display("FAIL rot_no_grant_exec[%0d]: got %b want 0000", n, req_ready);
            end
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || resp_id !== ID_W'(e) || resp_data !== exp_d) begin
                bad++; $display("FAIL rot_resp[%0d]: got valid=%b id=%0d data=%h want 1/%0d/%h",
                                n, resp_valid, resp_id, resp_data, e, exp_d);
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_arith;
        logic [3:0]  ops [9];
        logic [31:0] as  [9];
        logic [31:0] bs  [9];
        logic [31:0] ys  [9];
        ops[0] = 4'd1; as[0] = 32'h0000_0000; bs[0] = 32'h0000_0001; ys[0] = 32'hFFFF_FFFF;
        ops[1] = 4'd7; as[1] = 32'h8000_0000; bs[1] = 32'h0000_0024; ys[1] = 32'hF800_0000;
        ops[2] = 4'd8; as[2] = 32'hFFFF_FFFF; bs[2] = 32'h0000_0000; ys[2] = 32'h0000_0001;
        ops[3] = 4'd9; as[3] = 32'hFFFF_FFFF; bs[3] = 32'h0000_0000; ys[3] = 32'h0000_0000;
        ops[4] = 4'd0; as[4] = 32'hFFFF_FFFF; bs[4] = 32'h0000_0002; ys[4] = 32'h0000_0001;
        ops[5] = 4'd5; as[5] = 32'h0000_0001; bs[5] = 32'h0000_0021; ys[5] = 32'h0000_0002;
        ops[6] = 4'd6; as[6] = 32'h8000_0000; bs[6] = 32'h0000_001F; ys[6] = 32'h0000_0001;
        ops[7] = 4'd4; as[7] = 32'hF0F0_F0F0; bs[7] = 32'hFFFF_0000; ys[7] = 32'h0F0F_F0F0;
        ops[8] = 4'd2; as[8] = 32'h1234_5678; bs[8] = 32'h0000_FFFF; ys[8] = 32'h0000_5678;
        for (int n = 0; n < 9; n++) begin
            set_req(2, ops[n], as[n], bs[n]);
            req_valid = 4'b0100;
            #1;
            total++;
            if (req_ready !== 4'b0100) begin
                bad++; $display("FAIL arith_grant[%0d]: got %b want 0100", n, req_ready);
            end
            @(negedge clk);
            req_valid = 4'b0000;
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || resp_data !== ys[n] || resp_err !== 1'b0 || resp_id !== 2'd2) begin
                bad++; $display("FAIL arith_op%0d[%0d]: got valid=%b data=%h err=%b id=%0d want 1/%h/0/2",
                                ops[n], n, resp_valid, resp_data, resp_err, resp_id, ys[n]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_stall;
        set_req(3, 4'hC, 32'h1234_5678, 32'h9ABC_DEF0);
        req_valid  = 4'b1000;
        resp_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL ill_grant: got %b want 1000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'h0 || resp_id !== 2'd3) begin
            bad++; $display("FAIL ill_resp: got valid=%b err=%b data=%h id=%0d want 1/1/0/3",
                            resp_valid, resp_err, resp_data, resp_id);
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_id !== 2'd3 || resp_err !== 1'b1
                || req_ready !== 4'b0000) begin
                bad++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h id=%0d err=%b ready=%b want 1/0/3/1/0000",
                                n, resp_valid, resp_data, resp_id, resp_err, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL stall_release: got ready=%b valid=%b want 0001/0", req_ready, resp_valid);
        end
        // Withdraw before the edge: no grant may be taken.
        req_valid = 4'b0000;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL withdraw: got ready=%b valid=%b want 0000/0", req_ready, resp_valid);
        end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL withdraw_no_resp: got valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_reset_exec;
        set_req(0, 4'd0, 32'h0000_0010, 32'h0000_0020);
        set_req(1, 4'd0, 32'h0000_0005, 32'h0000_0006);
        req_valid = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL rx_grant: got %b want 0010", req_ready);
        end
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL rx_ready_in_rst: got %b want 0000", req_ready);
        end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_id !== 2'd0 || resp_err !== 1'b0
            || req_ready !== 4'b0000) begin
            bad++; $display("FAIL rx_after_rst: got valid=%b data=%h id=%0d err=%b ready=%b want 0/0/0/0/0000",
                            resp_valid, resp_data, resp_id, resp_err, req_ready);
        end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL rx_discarded: got valid=%b want 0", resp_valid);
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL rx_first_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0030 || resp_id !== 2'd0) begin
            bad++; $display("FAIL rx_resp: got valid=%b data=%h id=%0d want 1/00000030/0",
                            resp_valid, resp_data, resp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_pattern_1010;
        logic [3:0] exp_oh;
        int         e;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_req(1, 4'd0, 32'h1, 32'h1);
        set_req(3, 4'd0, 32'h3, 32'h3);
        req_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            e = 1;
`else
            e = (n % 2 == 0) ? 1 : 3;
`endif
            exp_oh = 4'b0001 << e;
            #1;
            total++;
            if (req_ready !== exp_oh) begin
                bad++; $display("FAIL p1010_grant[%0d]: got %b want %b", n, req_ready, exp_oh);
            end
            @(negedge clk);
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || resp_id !== ID_W'(e) || resp_data !== 32'(2 * e)) begin
                bad++; $display("FAIL p1010_resp[%0d]: got valid=%b id=%0d data=%h want 1/%0d/%0h",
                                n, resp_valid, resp_id, resp_data, e, 2 * e);
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        test_reset();
        test_basic_or();
        test_rotation();
        test_arith();
        test_illegal_stall();
        test_reset_exec();
        test_pattern_1010();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
